// File: rtl/fifo_ctrl_param_if.sv
// Request/response bundle between user request logic and the FIFO controller.
// The master drives requests; the slave (controller) drives RAM enables,
// pointers, occupancy and status flags.
interface fifo_ctrl_param_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              read;
    logic              write;
    logic              flush;
    logic              err_clr;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] writeAddr;
    logic [ADDR_W-1:0] readAddr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;
    logic              error;

    modport master (
        output read, write, flush, err_clr,
        input  wr_en, rd_en, writeAddr, readAddr, count,
        input  empty, full, almost_empty, almost_full,
        input  overflow, underflow, error
    );

    modport slave (
        input  read, write, flush, err_clr,
        output wr_en, rd_en, writeAddr, readAddr, count,
        output empty, full, almost_empty, almost_full,
        output overflow, underflow, error
    );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised FIFO controller: head/tail pointers and occupancy count for a
// dual-port RAM, with simultaneous read/write, flush, threshold flags and
// overflow/underflow reporting.
// Optional feature macro: FIFO_CTRL_STICKY_ERR_EN (sticky error register
// cleared by err_clr); when undefined, error is a combinational pulse.
module fifo_ctrl_param #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AFULL_TH  = (1 << ADDR_W) - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input logic              clk,
    input logic              reset,
    fifo_ctrl_param_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [ADDR_W-1:0] head_q;
    logic [ADDR_W-1:0] tail_q;
    logic [CNT_W-1:0]  count_q;

    logic empty_c;
    logic full_c;
    logic rd_acc_c;
    logic wr_acc_c;
    logic ovf_c;
    logic unf_c;

    // Request acceptance and error pulses; all qualified off while in reset.
    always_comb begin
        empty_c  = (count_q == '0);
        full_c   = (count_q == DEPTH_C);
        rd_acc_c = reset & bus.read & ~empty_c & ~bus.flush;
        wr_acc_c = reset & bus.write & ~bus.flush & (~full_c | rd_acc_c);
        ovf_c    = reset & bus.write & full_c & ~rd_acc_c & ~bus.flush;
        unf_c    = reset & bus.read & empty_c & ~bus.flush;
    end

    // Pointer and occupancy update; flush overrides any accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (rd_acc_c) head_q <= head_q + ADDR_W'(1);
            if (wr_acc_c) tail_q <= tail_q + ADDR_W'(1);
            if (wr_acc_c && !rd_acc_c)      count_q <= count_q + CNT_W'(1);
            else if (rd_acc_c && !wr_acc_c) count_q <= count_q - CNT_W'(1);
        end
    end

    assign bus.rd_en        = rd_acc_c;
    assign bus.wr_en        = wr_acc_c;
    assign bus.readAddr     = head_q;
    assign bus.writeAddr    = tail_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.overflow     = ovf_c;
    assign bus.underflow    = unf_c;

`ifdef FIFO_CTRL_STICKY_ERR_EN
    logic err_q;

    // Sticky error: a new event in the same cycle as err_clr keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (ovf_c || unf_c) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus.error = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.error      = ovf_c | unf_c;
`endif
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param at ADDR_W=3 (depth 8, almost_full
// at 6, almost_empty at 2). Vector table plus hand-written corner sequences;
// a queue of expected write addresses checks FIFO ordering of readAddr.
module tb_fifo_ctrl_param;
    localparam int unsigned ADDR_W = 3;

    logic clk;
    logic reset;

    fifo_ctrl_param_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_ctrl_param #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rd;
        bit wr;
        bit fl;
        bit ewr;
        bit erd;
        bit eov;
        bit eun;
        int cnt;
        int wa;
        int ra;
    } vec_t;

    vec_t vecs[$];
    int   addr_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   err_model = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input bit rd, input bit wr, input bit fl, input bit ewr,
                       input bit erd, input bit eov, input bit eun,
                       input int cnt, input int wa, input int ra);
        vec_t v;
        v.rd = rd; v.wr = wr; v.fl = fl;
        v.ewr = ewr; v.erd = erd; v.eov = eov; v.eun = eun;
        v.cnt = cnt; v.wa = wa; v.ra = ra;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rd, input bit wr, input bit fl, input bit clr);
        bus.read    = rd;
        bus.write   = wr;
        bus.flush   = fl;
        bus.err_clr = clr;
    endtask

    // Count-derived flags for depth 8, AFULL_TH 6, AEMPTY_TH 2.
    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, " empty"},        int'(bus.empty),        int'(cnt == 0));
        chk({tag, " full"},         int'(bus.full),         int'(cnt == 8));
        chk({tag, " almost_full"},  int'(bus.almost_full),  int'(cnt >= 6));
        chk({tag, " almost_empty"}, int'(bus.almost_empty), int'(cnt <= 2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0);
        reset = 1'b0;
        addr_q.delete();
        err_model = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst count", int'(bus.count), 0);
        chk("rst writeAddr", int'(bus.writeAddr), 0);
        chk("rst readAddr", int'(bus.readAddr), 0);
        chk("rst error", int'(bus.error), 0);
        chk("rst wr_en", int'(bus.wr_en), 0);
        chk_flags("rst", 0);
        reset = 1'b1;

        // Fill from reset: 8 accepted writes, then two overflow cycles.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 0, 0, 0, i, i, 0);
        for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, 1, 0, 8, 0, 0);
        // Full with read+write: both accepted, count holds at 8.
        for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 1, 0, 0, 8, i, i);
        // Drain all 8.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 1, 0, 0, 8 - i, 4, (4 + i) % 8);
        // Read while empty, then read+write while empty.
        add(1, 0, 0, 0, 0, 0, 1, 0, 4, 4);
        add(1, 1, 0, 1, 0, 0, 1, 0, 4, 4);
        add(0, 0, 0, 0, 0, 0, 0, 1, 5, 4);
        // Fill to 5 then flush with read and write high.
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 0, 0, 0, 1 + i, (5 + i) % 8, 4);
        add(1, 1, 1, 0, 0, 0, 0, 5, 1, 4);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            string tag;
            int    exp_err;
            tag = $sformatf("v%0d", k);
            @(negedge clk);
            drive(vecs[k].rd, vecs[k].wr, vecs[k].fl, 0);
            #2;
            chk({tag, " wr_en"},     int'(bus.wr_en),     int'(vecs[k].ewr));
            chk({tag, " rd_en"},     int'(bus.rd_en),     int'(vecs[k].erd));
            chk({tag, " overflow"},  int'(bus.overflow),  int'(vecs[k].eov));
            chk({tag, " underflow"}, int'(bus.underflow), int'(vecs[k].eun));
            chk({tag, " count"},     int'(bus.count),     vecs[k].cnt);
            chk({tag, " writeAddr"}, int'(bus.writeAddr), vecs[k].wa);
            chk({tag, " readAddr"},  int'(bus.readAddr),  vecs[k].ra);
            chk_flags(tag, vecs[k].cnt);
`ifdef FIFO_CTRL_STICKY_ERR_EN
            exp_err = int'(err_model);
            err_model = err_model | vecs[k].eov | vecs[k].eun;
`else
            exp_err = int'(vecs[k].eov | vecs[k].eun);
`endif
            chk({tag, " error"}, int'(bus.error), exp_err);
            // Ordering scoreboard: each accepted read must hit the oldest written address.
            if (bus.rd_en) begin
                if (addr_q.size() == 0) chk({tag, " sb nonempty"}, 0, 1);
                else chk({tag, " sb readAddr"}, int'(bus.readAddr), addr_q.pop_front());
            end
            if (vecs[k].ewr) addr_q.push_back(vecs[k].wa);
            if (vecs[k].fl) addr_q.delete();
        end
        chk("sb drained", addr_q.size(), 0);

        // Error reporting around a single underflow.
        @(negedge clk);
        drive(0, 0, 0, 1);
`ifdef FIFO_CTRL_STICKY_ERR_EN
        #2 chk("err held before clr", int'(bus.error), 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #2 chk("err cleared", int'(bus.error), 0);
        @(negedge clk);
        drive(1, 0, 0, 0);
        #2 chk("err same cycle", int'(bus.error), 0);
        chk("err underflow", int'(bus.underflow), 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #2 chk("err set", int'(bus.error), 1);
        @(negedge clk);
        #2 chk("err held", int'(bus.error), 1);
        @(negedge clk);
        drive(0, 0, 0, 1);
        #2 chk("err before clr edge", int'(bus.error), 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #2 chk("err after clr", int'(bus.error), 0);
`else
        #2 chk("err idle", int'(bus.error), 0);
        @(negedge clk);
        drive(1, 0, 0, 0);
        #2 chk("err pulse", int'(bus.error), 1);
        chk("err underflow", int'(bus.underflow), 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #2 chk("err pulse gone", int'(bus.error), 0);
`endif

        // Async reset mid-fill at count 3 with write still requested.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 0);
        end
        @(negedge clk);
        #1 chk("midfill count", int'(bus.count), 3);
        chk("midfill wr_en", int'(bus.wr_en), 1);
        #1 reset = 1'b0;
        #1;
        chk("arst count", int'(bus.count), 0);
        chk("arst writeAddr", int'(bus.writeAddr), 0);
        chk("arst readAddr", int'(bus.readAddr), 0);
        chk("arst wr_en", int'(bus.wr_en), 0);
        chk("arst error", int'(bus.error), 0);
        chk_flags("arst", 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        #2 chk("post arst count", int'(bus.count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
